ysyx_22051013_pipe_ctrl: RTL and testbench

//  Central hazard/sequencing controller for the 5-stage pipeline.

---
 rtl/ysyx_22051013_pipe_ctrl.sv | 119 +++++++++++
 tb/tb_ysyx_22051013_pipe_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22051013_pipe_ctrl.sv
// Hazard/sequencing controller: stall/flush for the pipeline registers and the EX->IF redirect handshake.
// Optional PIPE_CTRL_PERF_EN adds a saturating count of cycles in which the PC is held.
module ysyx_22051013_pipe_ctrl #(
  parameter int XLEN  = 64,
  parameter int RAW   = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_busy,
  input  logic             mem_busy,
  input  logic             ex_is_load,
  input  logic [RAW-1:0]   ex_rd,
  input  logic [RAW-1:0]   id_rs1,
  input  logic [RAW-1:0]   id_rs2,
  input  logic             id_rs1_en,
  input  logic             id_rs2_en,
  input  logic             ex_redirect,
  input  logic [XLEN-1:0]  ex_redirect_pc,
  output logic             pc_stall,
  output logic             id_stall,
  output logic             id_flush,
  output logic             ex_stall,
  output logic             ex_flush,
  output logic             mem_stall,
  output logic             redir_valid,
  output logic [XLEN-1:0]  redir_pc,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic {RUN = 1'b0, REDIR = 1'b1} state_t;

  state_t          state_q, state_d;
  logic            redir_valid_d;
  logic [XLEN-1:0] redir_pc_d;
  logic            load_use;
  logic            accept;

  // x0 is hard-wired zero, so a load targeting it never creates a dependency.
  assign load_use = ex_is_load && (ex_rd != '0) &&
                    ((id_rs1_en && (id_rs1 == ex_rd)) || (id_rs2_en && (id_rs2 == ex_rd)));

  // IF takes the redirect on any cycle it is not busy, independent of MEM.
  assign accept = redir_valid && !if_busy;

  always_comb begin
    pc_stall      = 1'b0;
    id_stall      = 1'b0;
    id_flush      = 1'b0;
    ex_stall      = 1'b0;
    ex_flush      = 1'b0;
    mem_stall     = 1'b0;
    state_d       = state_q;
    redir_valid_d = redir_valid;
    redir_pc_d    = redir_pc;

    if (mem_busy) begin
      // Whole pipe frozen; EX keeps any redirect stable until MEM is done.
      pc_stall  = 1'b1;
      id_stall  = 1'b1;
      ex_stall  = 1'b1;
      mem_stall = 1'b1;
      if (accept) begin
        redir_valid_d = 1'b0;
        state_d       = RUN;
      end
    end else if (ex_redirect) begin
      pc_stall      = 1'b1;
      id_flush      = 1'b1;
      ex_flush      = 1'b1;
      redir_valid_d = 1'b1;
      redir_pc_d    = ex_redirect_pc;
      state_d       = REDIR;
    end else if (state_q == REDIR) begin
      pc_stall = 1'b1;
      id_flush = 1'b1;
      if (accept) begin
        redir_valid_d = 1'b0;
        state_d       = RUN;
      end
    end else if (load_use) begin
      pc_stall = 1'b1;
      id_stall = 1'b1;
      ex_flush = 1'b1;
    end else if (if_busy) begin
      pc_stall = 1'b1;
      id_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      redir_valid <= 1'b0;
      redir_pc    <= '0;
    end else begin
      state_q     <= state_d;
      redir_valid <= redir_valid_d;
      redir_pc    <= redir_pc_d;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else if (pc_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_ysyx_22051013_pipe_ctrl.sv
// Self-checking bench for ysyx_22051013_pipe_ctrl: directed scenarios plus randomized traffic against a priority model.
module tb_ysyx_22051013_pipe_ctrl;

  localparam int XLEN  = 64;
  localparam int RAW   = 5;
  localparam int CNT_W = 32;

  logic             clk;
  logic             rst;
  logic             if_busy, mem_busy, ex_is_load;
  logic [RAW-1:0]   ex_rd, id_rs1, id_rs2;
  logic             id_rs1_en, id_rs2_en;
  logic             ex_redirect;
  logic [XLEN-1:0]  ex_redirect_pc;
  logic             pc_stall, id_stall, id_flush, ex_stall, ex_flush, mem_stall;
  logic             redir_valid;
  logic [XLEN-1:0]  redir_pc;
  logic [CNT_W-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  // Reference state: a pending redirect and its target, plus the stall count.
  logic             m_rv;
  logic [XLEN-1:0]  m_pc;
  logic [CNT_W-1:0] m_cnt;

  ysyx_22051013_pipe_ctrl #(.XLEN(XLEN), .RAW(RAW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .if_busy(if_busy), .mem_busy(mem_busy),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_en(id_rs1_en), .id_rs2_en(id_rs2_en), .ex_redirect(ex_redirect),
    .ex_redirect_pc(ex_redirect_pc), .pc_stall(pc_stall), .id_stall(id_stall),
    .id_flush(id_flush), .ex_stall(ex_stall), .ex_flush(ex_flush),
    .mem_stall(mem_stall), .redir_valid(redir_valid), .redir_pc(redir_pc),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bit order: {pc_stall, id_stall, id_flush, ex_stall, ex_flush, mem_stall}
  function automatic logic [5:0] obs_ctrl();
    return {pc_stall, id_stall, id_flush, ex_stall, ex_flush, mem_stall};
  endfunction

  function automatic logic [5:0] model_ctrl();
    bit hz, mb, rd, rq, lu, fb;
    hz = ex_is_load && (ex_rd != 0) &&
         ((id_rs1_en && id_rs1 == ex_rd) || (id_rs2_en && id_rs2 == ex_rd));
    mb = mem_busy;
    rd = !mb && ex_redirect;
    rq = !mb && !rd && m_rv;
    lu = !mb && !rd && !rq && hz;
    fb = !mb && !rd && !rq && !lu && if_busy;
    return {mb | rd | rq | lu | fb, mb | lu, rd | rq | fb, mb, rd | lu, mb};
  endfunction

  task automatic set_idle();
    if_busy = 0; mem_busy = 0; ex_is_load = 0; ex_rd = 0; id_rs1 = 0; id_rs2 = 0;
    id_rs1_en = 0; id_rs2_en = 0; ex_redirect = 0; ex_redirect_pc = '0;
  endtask

  task automatic model_reset();
    m_rv = 0; m_pc = '0; m_cnt = '0;
  endtask

  // Advance one clock; the model consumes the same inputs the DUT sees at the edge.
  task automatic tick();
    logic             n_rv;
    logic [XLEN-1:0]  n_pc;
    logic [CNT_W-1:0] n_cnt;
    logic [5:0]       e;
    e = model_ctrl();
    n_rv = m_rv; n_pc = m_pc; n_cnt = m_cnt;
    if (!mem_busy && ex_redirect) begin
      n_rv = 1; n_pc = ex_redirect_pc;
    end else if (m_rv && !if_busy) begin
      n_rv = 0;
    end
`ifdef PIPE_CTRL_PERF_EN
    if (e[5] && m_cnt != {CNT_W{1'b1}}) n_cnt = m_cnt + 1;
`endif
    @(posedge clk); #1;
    m_rv = n_rv; m_pc = n_pc; m_cnt = n_cnt;
  endtask

  task automatic test_reset();
    set_idle();
    rst = 0;
    model_reset();
    #3;
    checks++;
    if ({redir_valid, redir_pc, stall_cnt, obs_ctrl()} !== '0) begin
      errors++;
      $display("FAIL reset: rv=%0b pc=%h cnt=%0d ctrl=%b, required all zero",
               redir_valid, redir_pc, stall_cnt, obs_ctrl());
    end
    #4 rst = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_load_use();
    // Dependency on a real register: one bubble.
    set_idle();
    ex_is_load = 1; ex_rd = 5; id_rs1 = 5; id_rs1_en = 1;
    @(negedge clk);
    checks++;
    if (obs_ctrl() !== 6'b110010) begin
      errors++; $display("FAIL load_use_rs1: ctrl=%b required 110010", obs_ctrl());
    end
    tick();
    ex_is_load = 0;
    @(negedge clk);
    checks++;
    if (obs_ctrl() !== 6'b000000) begin
      errors++; $display("FAIL load_use_clear: ctrl=%b required 000000", obs_ctrl());
    end
    tick();
    // Match through rs2 only.
    set_idle();
    ex_is_load = 1; ex_rd = 7; id_rs1 = 7; id_rs1_en = 0; id_rs2 = 7; id_rs2_en = 1;
    @(negedge clk);
    checks++;
    if (obs_ctrl() !== 6'b110010) begin
      errors++; $display("FAIL load_use_rs2: ctrl=%b required 110010", obs_ctrl());
    end
    tick();
    // x0 never creates a hazard.
    set_idle();
    ex_is_load = 1; ex_rd = 0; id_rs1 = 0; id_rs1_en = 1; id_rs2 = 0; id_rs2_en = 1;
    @(negedge clk);
    checks++;
    if (obs_ctrl() !== 6'b000000) begin
      errors++; $display("FAIL load_use_x0: ctrl=%b required 000000", obs_ctrl());
    end
    tick();
    set_idle();
  endtask

  task automatic test_redirect();
    set_idle();
    ex_redirect = 1; ex_redirect_pc = 64'h0000_0000_8000_0100;
    @(negedge clk);
    checks++;
    if (obs_ctrl() !== 6'b101010 || redir_valid !== 1'b0) begin
      errors++; $display("FAIL redirect_same_cycle: ctrl=%b rv=%0b required 101010 rv=0", obs_ctrl(), redir_valid);
    end
    tick();
    set_idle();
    @(negedge clk);
    checks++;
    if (redir_valid !== 1'b1 || redir_pc !== 64'h0000_0000_8000_0100 || obs_ctrl() !== 6'b101000) begin
      errors++; $display("FAIL redirect_req: rv=%0b pc=%h ctrl=%b required rv=1 pc=80000100 ctrl=101000",
                         redir_valid, redir_pc, obs_ctrl());
    end
    tick();
    @(negedge clk);
    checks++;
    if (redir_valid !== 1'b0 || obs_ctrl() !== 6'b000000) begin
      errors++; $display("FAIL redirect_done: rv=%0b ctrl=%b required rv=0 ctrl=000000", redir_valid, obs_ctrl());
    end
    tick();
  endtask

  task automatic test_redirect_wait();
    int high;
    set_idle();
    ex_redirect = 1; ex_redirect_pc = 64'h0000_0000_8000_2000;
    tick();
    ex_redirect = 0;
    high = 0;
    for (int c = 0; c < 6; c++) begin
      if_busy = (c < 3);
      @(negedge clk);
      if (redir_valid === 1'b1) high++;
      if (c < 4) begin
        checks++;
        if (redir_valid !== 1'b1 || redir_pc !== 64'h0000_0000_8000_2000 || obs_ctrl() !== 6'b101000) begin
          errors++; $display("FAIL redirect_wait_c%0d: rv=%0b pc=%h ctrl=%b required rv=1 pc=80002000 ctrl=101000",
                             c, redir_valid, redir_pc, obs_ctrl());
        end
      end
      tick();
    end
    checks++;
    if (high != 4) begin
      errors++; $display("FAIL redirect_wait_len: rv high %0d cycles, required 4", high);
    end
    set_idle();
  endtask

  task automatic test_mem_busy_redirect();
    set_idle();
    mem_busy = 1; ex_redirect = 1; ex_redirect_pc = 64'h0000_0000_8000_0300;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (obs_ctrl() !== 6'b110101 || redir_valid !== 1'b0) begin
        errors++; $display("FAIL mem_busy_c%0d: ctrl=%b rv=%0b required 110101 rv=0", c, obs_ctrl(), redir_valid);
      end
      tick();
    end
    mem_busy = 0;
    @(negedge clk);
    checks++;
    if (obs_ctrl() !== 6'b101010 || redir_valid !== 1'b0) begin
      errors++; $display("FAIL mem_release: ctrl=%b rv=%0b required 101010 rv=0", obs_ctrl(), redir_valid);
    end
    tick();
    set_idle();
    @(negedge clk);
    checks++;
    if (redir_valid !== 1'b1 || redir_pc !== 64'h0000_0000_8000_0300) begin
      errors++; $display("FAIL mem_release_req: rv=%0b pc=%h required rv=1 pc=80000300", redir_valid, redir_pc);
    end
    tick();
  endtask

  task automatic test_reset_mid_redir();
    logic [CNT_W-1:0] exp_cnt;
    set_idle();
    ex_redirect = 1; ex_redirect_pc = 64'h0000_0000_8000_0400;
    tick();
    set_idle();
    if_busy = 1;
    #2 rst = 0;
    model_reset();
    #1;
    checks++;
    if (redir_valid !== 1'b0 || redir_pc !== '0 || stall_cnt !== '0) begin
      errors++; $display("FAIL reset_mid_redir: rv=%0b pc=%h cnt=%0d required 0 0 0", redir_valid, redir_pc, stall_cnt);
    end
    if_busy = 0;
    #3 rst = 1;
    @(posedge clk); #1;
    if_busy = 1;
    for (int c = 0; c < 5; c++) tick();
    if_busy = 0;
`ifdef PIPE_CTRL_PERF_EN
    exp_cnt = 5;
`else
    exp_cnt = 0;
`endif
    @(negedge clk);
    checks++;
    if (stall_cnt !== exp_cnt) begin
      errors++; $display("FAIL stall_cnt: cnt=%0d required %0d", stall_cnt, exp_cnt);
    end
    tick();
  endtask

  task automatic test_random();
    logic [5:0] e;
    for (int c = 0; c < 400; c++) begin
      mem_busy       = !m_rv && ($urandom_range(0, 99) < 20);
      if_busy        = ($urandom_range(0, 99) < 30);
      ex_redirect    = ($urandom_range(0, 99) < 15);
      ex_redirect_pc = {$urandom, $urandom};
      ex_is_load     = ($urandom_range(0, 99) < 40);
      ex_rd          = RAW'($urandom_range(0, 3));
      id_rs1         = RAW'($urandom_range(0, 3));
      id_rs2         = RAW'($urandom_range(0, 3));
      id_rs1_en      = $urandom_range(0, 1);
      id_rs2_en      = $urandom_range(0, 1);
      @(negedge clk);
      e = model_ctrl();
      checks++;
      if (obs_ctrl() !== e || redir_valid !== m_rv || redir_pc !== m_pc || stall_cnt !== m_cnt) begin
        errors++;
        $display("FAIL random_c%0d: ctrl=%b rv=%0b pc=%h cnt=%0d required ctrl=%b rv=%0b pc=%h cnt=%0d",
                 c, obs_ctrl(), redir_valid, redir_pc, stall_cnt, e, m_rv, m_pc, m_cnt);
      end
      checks++;
      if (id_stall === 1'b1 && id_flush === 1'b1) begin
        errors++; $display("FAIL random_excl_c%0d: id_stall=1 id_flush=1 required not both", c);
      end
      tick();
    end
    set_idle();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_redirect();
    test_redirect_wait();
    test_mem_busy_redirect();
    test_reset_mid_redir();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
